// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, clog2 and parameter-legality helper for the FIFO slice
package fifo_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic bit params_ok(input int width, input int depth, input int af,
                                     input int ae, input int fwft);
        return width >= 1 && depth >= 2 && (depth & (depth - 1)) == 0 &&
               af >= 1 && af <= depth && ae >= 0 && ae < depth && (fwft == 0 || fwft == 1);
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH register array, synchronous write, asynchronous read
//   clk, we, wr_addr, wr_data : write port
//   rd_addr -> rd_data        : combinational read port
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [clog2(DEPTH)-1:0]    wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [clog2(DEPTH)-1:0]    rd_addr,
    output logic [WIDTH-1:0]           rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[wr_addr] <= wr_data;
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: synchronous FIFO with count, almost flags, sticky errors and optional FWFT
//   clk, rst (async active-low)
//   wr_en/data_in, rd_en -> data_out/valid
//   empty, full, almost_empty, almost_full, count : registered status
//   overflow, underflow : sticky errors, cleared by clr_err
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [clog2(DEPTH):0]    count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);
    localparam int ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W:0]   C1    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   FULL_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_C  = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0]   AE_C  = (ADDR_W + 1)'(AE_LEVEL);
    localparam logic [ADDR_W-1:0] P1    = ADDR_W'(1);

    if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_bad_params
        $error("sync_fifo_flags: illegal parameter combination");
    end

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wr_acc, rd_acc, valid_r;
    logic [WIDTH-1:0]  mem_rd, dout_r;

    fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we      (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd)
    );

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc  = rd_en && !empty;
        wr_acc  = wr_en && (!full || rd_acc);
        cnt_nxt = (wr_acc && !rd_acc) ? count + C1 :
                  (rd_acc && !wr_acc) ? count - C1 : count;
    end

    // Flags are registered from the next count so they never depend combinationally on wr_en/rd_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            valid_r      <= 1'b0;
            dout_r       <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + P1;
            if (rd_acc) rd_ptr <= rd_ptr + P1;
            count        <= cnt_nxt;
            empty        <= cnt_nxt == '0;
            full         <= cnt_nxt == FULL_C;
            almost_empty <= cnt_nxt <= AE_C;
            almost_full  <= cnt_nxt >= AF_C;
            overflow     <= (wr_en && !wr_acc) || (overflow && !clr_err);
            underflow    <= (rd_en && !rd_acc) || (underflow && !clr_err);
            valid_r      <= rd_acc;
            if (rd_acc) dout_r <= mem_rd;
        end
    end

    // FWFT shows the head directly; it is forced to zero while empty so reset clears data_out.
    assign data_out = (FWFT != 0) ? (empty ? '0 : mem_rd) : dout_r;
    assign valid    = (FWFT != 0) ? !empty : valid_r;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: randomized + directed check of both read modes against a queue model
module tb_sync_fifo_flags;
    logic       clk = 1'b0, rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] dout0, dout1;
    logic [3:0] cnt0, cnt1;
    logic       val0, emp0, ful0, ae0, af0, ovf0, udf0;
    logic       val1, emp1, ful1, ae1, af1, ovf1, udf1;

    int         n_chk = 0, n_pass = 0;
    logic [7:0] q[$];
    logic       m_ovf, m_udf, m_valid;
    logic [7:0] m_dout;

    sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout0), .valid(val0), .empty(emp0), .full(ful0),
        .almost_empty(ae0), .almost_full(af0), .count(cnt0),
        .overflow(ovf0), .underflow(udf0), .clr_err(clr_err)
    );

    sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout1), .valid(val1), .empty(emp1), .full(ful1),
        .almost_empty(ae1), .almost_full(af1), .count(cnt1),
        .overflow(ovf1), .underflow(udf1), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_valid = 1'b0;
        m_dout = '0;
    endtask

    task automatic model_edge();
        bit ra, wa;
        ra = rd_en && q.size() > 0;
        wa = wr_en && (q.size() < 8 || ra);
        m_ovf = (wr_en && !wa) || (m_ovf && !clr_err);
        m_udf = (rd_en && !ra) || (m_udf && !clr_err);
        m_valid = ra;
        if (ra) m_dout = q.pop_front();
        if (wa) q.push_back(data_in);
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count", 32'(cnt0), 32'(n));
        chk("empty", 32'(emp0), 32'(n == 0));
        chk("full", 32'(ful0), 32'(n == 8));
        chk("almost_empty", 32'(ae0), 32'(n <= 2));
        chk("almost_full", 32'(af0), 32'(n >= 6));
        chk("overflow", 32'(ovf0), 32'(m_ovf));
        chk("underflow", 32'(udf0), 32'(m_udf));
        chk("valid", 32'(val0), 32'(m_valid));
        chk("data_out", 32'(dout0), 32'(m_dout));
        chk("f_count", 32'(cnt1), 32'(n));
        chk("f_flags", 32'({emp1, ful1, ae1, af1, ovf1, udf1}),
            32'({n == 0, n == 8, n <= 2, n >= 6, m_ovf, m_udf}));
        chk("f_valid", 32'(val1), 32'(n != 0));
        chk("f_data_out", 32'(dout1), 32'(n != 0 ? q[0] : 8'h00));
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en = w;
        data_in = d;
        rd_en = r;
        clr_err = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        // fill, overflow, drain, underflow, clear
        for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_last", 32'(dout0), 32'h08);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("underflow_hold", 32'(dout0), 32'h08);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        // simultaneous at full and at empty
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("aa_last", 32'(dout0), 32'hAA);
        cyc(1'b1, 8'h44, 1'b1, 1'b0);
        chk("empty_rw_count", 32'(cnt0), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        // pointer wrap
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        // FWFT fall-through
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("fwft_head", 32'({val1, dout1}), 32'h15A);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        // async reset between edges
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        wr_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk) rst = 1'b1;
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("reset_reread", 32'(dout0), 32'h33);
        // randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 600; i++) begin
            int pw;
            pw = ((i / 50) % 2 == 0) ? 75 : 30;
            cyc(($urandom_range(0, 99) < pw), 8'($urandom), ($urandom_range(0, 99) < 100 - pw),
                ($urandom_range(0, 15) == 0));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
